// File: rtl/definitions.sv
// Shared BeeF core type definitions: program counter type and hardware loop
// stack constants used by the loop-address source and its skip controller.
package definitions;

  localparam int PC_BITS    = 16;
  localparam int LOOP_DEPTH = 16;

  typedef logic [PC_BITS-1:0] PROGRAM_COUNTER;
  typedef PROGRAM_COUNTER     LOOP_ADDR;

  typedef enum logic {
    LOOP_IDLE = 1'b0,
    LOOP_SKIP = 1'b1
  } loop_state;

endpackage

// File: rtl/loop_stack_unit_skip_fsm.sv
// Skip controller for `[` with a zero accumulator: tracks bracket nesting
// while fetch discards instructions up to the matching `]`.
module loop_skip_fsm
  import definitions::*;
#(
  parameter int SKIP_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic skip_start,
  input  logic open_seen,
  input  logic close_seen,
  output logic skipping,
  output logic sat_error
);

  loop_state             state_q, state_d;
  logic [SKIP_WIDTH-1:0] depth_q, depth_d;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    sat_error = 1'b0;
    unique case (state_q)
      LOOP_IDLE: begin
        if (skip_start) begin
          state_d = LOOP_SKIP;
          depth_d = SKIP_WIDTH'(1);
        end
      end
      LOOP_SKIP: begin
        if (open_seen && !close_seen) begin
          // Saturate rather than wrap; the lost nesting level is reported.
          if (&depth_q) sat_error = 1'b1;
          else          depth_d   = depth_q + SKIP_WIDTH'(1);
        end else if (close_seen && !open_seen) begin
          if (depth_q <= SKIP_WIDTH'(1)) begin
            depth_d = '0;
            state_d = LOOP_IDLE;
          end else begin
            depth_d = depth_q - SKIP_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = LOOP_IDLE;
        depth_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOOP_IDLE;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
    end
  end

  assign skipping = (state_q == LOOP_SKIP);

endmodule

// File: rtl/loop_stack_unit.sv
// Hardware loop-address stack for the BeeF core: holds loop-body start
// addresses for `[`/`]` and exposes the top entry as pc_loaded for fetch.
module loop_stack_unit
  import definitions::*;
#(
  parameter int PC_WIDTH   = PC_BITS,
  parameter int DEPTH      = LOOP_DEPTH,
  parameter int SKIP_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                push,
  input  logic                pop,
  input  logic                skip_start,
  input  logic                open_seen,
  input  logic                close_seen,
  output logic [PC_WIDTH-1:0] pc_loaded,
  output logic                skipping,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic                underflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [PC_WIDTH-1:0] entry_q [DEPTH];
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic                wr_en;
  logic [AW-1:0]       wr_idx;
  logic [AW-1:0]       top_idx;
  logic [PC_WIDTH-1:0] push_addr;
  logic                stack_active;
  logic                sat_error;

  loop_skip_fsm #(
    .SKIP_WIDTH(SKIP_WIDTH)
  ) u_skip_fsm (
    .clk       (clk),
    .reset     (reset),
    .skip_start(skip_start),
    .open_seen (open_seen),
    .close_seen(close_seen),
    .skipping  (skipping),
    .sat_error (sat_error)
  );

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign top_idx   = count_q[AW-1:0] - AW'(1);
  assign push_addr = pc + PC_WIDTH'(1);
  assign pc_loaded = empty ? '0 : entry_q[top_idx];

  // The stack is frozen while skipping and on the cycle a skip begins.
  assign stack_active = !skipping && !skip_start;

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q | sat_error;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    wr_idx      = count_q[AW-1:0];
    if (stack_active) begin
      if (push && pop && !empty) begin
        // Replace the top entry: loop exit and re-entry in one instruction.
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (push) begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
      end else if (pop) begin
        if (empty) underflow_d = 1'b1;
        else       count_d     = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the entry array has no reset; count alone defines which entries are
  // valid, so clearing storage would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) entry_q[wr_idx] <= push_addr;
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_loop_stack_unit.sv
// Directed self-checking bench for loop_stack_unit with hand-computed
// expectations for stack, overflow/underflow, skip nesting and reset.
module tb_loop_stack_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        push, pop, skip_start, open_seen, close_seen;
  logic [15:0] pc_loaded;
  logic        skipping, full, empty, overflow, underflow;

  int checks = 0;
  int errors = 0;

  loop_stack_unit dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .push      (push),
    .pop       (pop),
    .skip_start(skip_start),
    .open_seen (open_seen),
    .close_seen(close_seen),
    .pc_loaded (pc_loaded),
    .skipping  (skipping),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply the currently driven inputs for one edge, then return to idle
  // inputs; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    reset = 1'b0; push = 1'b0; pop = 1'b0; skip_start = 1'b0;
    open_seen = 1'b0; close_seen = 1'b0;
  endtask

  task automatic do_push(input logic [15:0] addr);
    pc = addr; push = 1'b1; tick();
  endtask

  task automatic do_pop();
    pop = 1'b1; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; tick();
  endtask

  initial begin
    reset = 1'b1; pc = '0; push = 1'b0; pop = 1'b0; skip_start = 1'b0;
    open_seen = 1'b0; close_seen = 1'b0;
    tick();
    do_reset();
    check("rst_pc_loaded", pc_loaded, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_skipping", skipping, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);

    // Push/peek/pop
    do_push(16'd5);
    check("push5_pc_loaded", pc_loaded, 6);
    check("push5_empty", empty, 0);
    do_push(16'd9);
    check("push9_pc_loaded", pc_loaded, 10);
    do_pop();
    check("pop1_pc_loaded", pc_loaded, 6);
    do_pop();
    check("pop2_empty", empty, 1);
    check("pop2_pc_loaded", pc_loaded, 0);
    check("pop2_underflow", underflow, 0);

    // Fill and overflow
    for (int i = 0; i < 16; i++) do_push(16'(i));
    check("fill_full", full, 1);
    check("fill_pc_loaded", pc_loaded, 16);
    check("fill_overflow", overflow, 0);
    do_push(16'd100);
    check("ovf_pc_loaded", pc_loaded, 16);
    check("ovf_flag", overflow, 1);
    tick();
    check("ovf_sticky", overflow, 1);
    check("ovf_full", full, 1);

    // Drain, then underflow and wrap
    for (int i = 15; i > 0; i--) do_pop();
    check("drain_last_pc_loaded", pc_loaded, 1);
    do_pop();
    check("drain_empty", empty, 1);
    do_pop();
    check("unf_flag", underflow, 1);
    check("unf_empty", empty, 1);
    do_push(16'hFFFF);
    check("wrap_pc_loaded", pc_loaded, 16'h0000);
    check("wrap_empty", empty, 0);
    do_pop();
    check("wrap_pop_empty", empty, 1);
    check("unf_sticky", underflow, 1);

    // Nested skip with frozen stack
    do_reset();
    check("rst2_overflow", overflow, 0);
    check("rst2_underflow", underflow, 0);
    do_push(16'd40);
    skip_start = 1'b1; tick();
    check("skip_start_skipping", skipping, 1);
    open_seen = 1'b1; tick();
    open_seen = 1'b1; tick();
    close_seen = 1'b1; tick();
    check("skip_close1_skipping", skipping, 1);
    do_push(16'd77);
    check("skip_push_frozen", pc_loaded, 41);
    pop = 1'b1; tick();
    check("skip_pop_frozen", pc_loaded, 41);
    open_seen = 1'b1; close_seen = 1'b1; tick();
    close_seen = 1'b1; tick();
    check("skip_close2_skipping", skipping, 1);
    close_seen = 1'b1; tick();
    check("skip_close3_skipping", skipping, 0);
    check("skip_end_pc_loaded", pc_loaded, 41);
    check("skip_end_empty", empty, 0);

    // Simultaneous push and pop with count=2
    do_push(16'd50);
    check("cnt2_pc_loaded", pc_loaded, 51);
    pc = 16'd20; push = 1'b1; pop = 1'b1; tick();
    check("pushpop_pc_loaded", pc_loaded, 21);
    do_pop();
    check("pushpop_count2_below", pc_loaded, 41);
    do_pop();
    check("pushpop_drained", empty, 1);

    // Push+pop on empty acts as push
    pc = 16'd7; push = 1'b1; pop = 1'b1; tick();
    check("pushpop_empty_pc_loaded", pc_loaded, 8);
    check("pushpop_empty_underflow", underflow, 0);
    do_pop();

    // skip_start with push in the same cycle: push ignored
    pc = 16'd3; push = 1'b1; skip_start = 1'b1; tick();
    check("skip_push_same_cycle_skipping", skipping, 1);
    check("skip_push_same_cycle_empty", empty, 1);
    close_seen = 1'b1; tick();
    check("skip_single_close", skipping, 0);

    // Reset in SKIP at depth 3
    do_push(16'd60);
    skip_start = 1'b1; tick();
    open_seen = 1'b1; tick();
    open_seen = 1'b1; tick();
    check("pre_rst_skipping", skipping, 1);
    do_reset();
    check("rst_skip_skipping", skipping, 0);
    check("rst_skip_empty", empty, 1);
    check("rst_skip_pc_loaded", pc_loaded, 0);

    // Skip depth saturation sets overflow
    skip_start = 1'b1; tick();
    for (int i = 0; i < 254; i++) begin
      open_seen = 1'b1; tick();
    end
    check("sat_before_overflow", overflow, 0);
    open_seen = 1'b1; tick();
    check("sat_overflow", overflow, 1);
    check("sat_skipping", skipping, 1);
    close_seen = 1'b1; tick();
    check("sat_after_close_skipping", skipping, 1);
    do_reset();
    check("sat_rst_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/loop_stack_unit.md
Name: loop_stack_unit

Overview:
- Hardware loop-address source for the BeeF core; produces the `pc_loaded` value consumed by `fetch_unit` when `pc_src` selects a loaded branch target.
- On `[` with a non-zero accumulator, it pushes the loop-body start address. On `]` with a non-zero accumulator, it supplies the body address. On `]` with a zero accumulator, it pops.
- On `[` with a zero accumulator, it runs a skip FSM. The FSM tracks bracket nesting so fetch can discard instructions up to the matching `]`.

Parameters:
- PC_WIDTH, 16, width of PROGRAM_COUNTER.
- DEPTH, 16, maximum nested loop levels stored.
- SKIP_WIDTH, 8, width of the skip nesting counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  PC_WIDTH  current program counter (address of the instruction being executed).
- push  in  1  `[` executed with acc_zero=0.
- pop  in  1  `]` executed with acc_zero=1.
- skip_start  in  1  `[` executed with acc_zero=1.
- open_seen  in  1  `[` fetched while skipping.
- close_seen  in  1  `]` fetched while skipping.
- pc_loaded  out  PC_WIDTH  top-of-stack loop-body address; 0 when empty.
- skipping  out  1  high while the skip FSM is in SKIP; fetch suppresses execution.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: push attempted while full, or skip depth saturated.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (synchronous, active-high): count=0, FSM=IDLE, skip depth=0, overflow=0, underflow=0. Storage array is not cleared.
- Reset outputs: pc_loaded=0, skipping=0, empty=1, full=0. Reset mid-skip or mid-loop returns to this state on the next edge.
- Storage: DEPTH x PC_WIDTH registers; count is clog2(DEPTH)+1 bits.
- Push value: pc+1, truncated modulo 2^PC_WIDTH (pc=16'hFFFF stores 16'h0000).
- pc_loaded: combinational read of entry[count-1] from registered state. It updates the cycle after a push or pop (0-cycle read, 1-cycle write latency).
- IDLE state, per edge:
  - push only, not full: entry[count]<=pc+1, count+1.
  - push only, full: no change; overflow<=1.
  - pop only, not empty: count-1.
  - pop only, empty: no change; underflow<=1.
  - push and pop together, not empty: entry[count-1]<=pc+1, count unchanged.
  - push and pop together, empty: treated as push only.
  - skip_start: go to SKIP, depth<=1; push/pop in the same cycle are ignored.
- SKIP state:
  - push, pop and skip_start are ignored; the stack is frozen.
  - open_seen only: depth+1. At all-ones, depth holds and overflow<=1.
  - close_seen only, depth==1: depth<=0, go to IDLE. skipping drops the cycle after the matching `]` edge.
  - close_seen only, depth>1: depth-1.
  - open_seen and close_seen together: depth unchanged.
- skipping = (state==SKIP); registered, no combinational path from inputs.
- full and empty are decoded from registered count.
- overflow and underflow clear only on reset.

Decomposition:
- Add to the shared `definitions` package:
  - loop_state enum {LOOP_IDLE, LOOP_SKIP}.
  - LOOP_DEPTH constant (16).
  - LOOP_ADDR typedef, aliased to PROGRAM_COUNTER.
- Sub-module loop_skip_fsm: contains the state register and nesting counter. Inputs: skip_start, open_seen, close_seen. Outputs: skipping, sat_error.
- The stack array and count stay in loop_stack_unit.

Test Plan:
- Reset then idle: after reset, pc_loaded=0, empty=1, full=0, skipping=0, overflow=0, underflow=0.
- Push/peek/pop:
  - push with pc=5 -> next cycle pc_loaded=6, empty=0.
  - push with pc=9 -> pc_loaded=10.
  - pop -> pc_loaded=6.
  - pop -> empty=1, pc_loaded=0.
- Full/overflow: 16 pushes with pc=0..15 -> full=1, pc_loaded=16. A 17th push with pc=100 -> pc_loaded still 16, overflow=1 and stays 1.
- Underflow and wrap:
  - pop while empty -> underflow=1, count stays 0.
  - push with pc=16'hFFFF -> pc_loaded=16'h0000.
- Nested skip:
  - skip_start -> skipping=1.
  - open_seen, open_seen, then close_seen x2 -> skipping still 1.
  - third close_seen -> skipping=0 next cycle.
  - A push during SKIP leaves the stack unchanged.
- Simultaneous and reset events:
  - push+pop together with count=2, pc=20 -> count=2, pc_loaded=21.
  - reset asserted in SKIP at depth 3 -> skipping=0, empty=1 next cycle.
